// File: rtl/ether_frame_tx.sv
// ether_frame_tx: serialises one Ethernet II frame per start onto RMII TX (ETHER_TX_IFG_EN adds a 48-cycle inter-frame gap)
module ether_frame_tx #(
  parameter logic [47:0] SRC_MAC = 48'h0,
  parameter logic [47:0] DST_MAC = 48'h0,
  parameter logic [15:0] ETHERTYPE = 16'h0,
  parameter int PAYLOAD_LENGTH_BYTES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic [8*PAYLOAD_LENGTH_BYTES-1:0] payload,
  input  logic start,
  output logic busy,
  output logic txen,
  output logic [1:0] txd
);
  localparam int P = PAYLOAD_LENGTH_BYTES;
  localparam int PAD_B = (P >= 46) ? 0 : 46 - P;
  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, IFG} state_t;
`ifdef ETHER_TX_IFG_EN
  localparam state_t AFTER_FCS = IFG;
`else
  localparam state_t AFTER_FCS = IDLE;
`endif
  state_t state_q, state_d, nxt;
  logic [10:0] byte_q, byte_d, len;
  logic [1:0] dib_q, dib_d, txd_q, txd_d;
  logic [31:0] crc_q, crc_d;
  logic [8*P-1:0] pl_q, pl_d;
  logic [7:0] cur_byte;
  logic txen_q, txen_d, busy_q, busy_d, step, last;

  function automatic logic [31:0] crc2(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) r = (r[0] ^ d[i]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  // state/counters track the dibit on the wire now; outputs are computed for the next position so they can be registered
  always_comb begin
    len = state_q == PREAMBLE ? 11'd8 : state_q == HEADER ? 11'd14 : state_q == PAYLOAD ? 11'(P) :
          state_q == PAD ? 11'(PAD_B) : state_q == IFG ? 11'd48 : 11'd4;
    step = state_q == IFG || dib_q == 2'd3;
    last = step && byte_q == len - 11'd1;
    nxt = state_q == PREAMBLE ? HEADER : state_q == HEADER ? PAYLOAD : state_q == PAYLOAD ? (PAD_B > 0 ? PAD : FCS) :
          state_q == PAD ? FCS : state_q == FCS ? AFTER_FCS : IDLE;
    state_d = state_q == IDLE ? (start ? PREAMBLE : IDLE) : last ? nxt : state_q;
    byte_d = (state_q == IDLE || last) ? 11'd0 : byte_q + {10'd0, step};
    dib_d = (state_q == IDLE || last || state_q == IFG) ? 2'd0 : dib_q + 2'd1;
    pl_d = (state_q == IDLE && start) ? payload : pl_q;
    crc_d = state_q == IDLE ? 32'hFFFFFFFF :
            (state_q == HEADER || state_q == PAYLOAD || state_q == PAD) ? crc2(crc_q, txd_q) :
            state_q == FCS ? crc_q >> 2 : crc_q;
    cur_byte = state_d == PREAMBLE ? (byte_d == 11'd7 ? 8'hD5 : 8'h55) :
               state_d == HEADER ? 8'((HDR << {byte_d, 3'b0}) >> 104) :
               state_d == PAYLOAD ? 8'((pl_q << {byte_d, 3'b0}) >> (8 * P - 8)) : 8'h00;
    txen_d = !(state_d == IDLE || state_d == IFG);
    txd_d = !txen_d ? 2'b00 : state_d == FCS ? ~crc_d[1:0] : 2'(cur_byte >> {dib_d, 1'b0});
    busy_d = state_d != IDLE;
  end

  // single register stage for FSM, counters, CRC, latched payload and the PHY-facing outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      byte_q <= '0;
      dib_q <= '0;
      crc_q <= 32'hFFFFFFFF;
      pl_q <= '0;
      txen_q <= 1'b0;
      txd_q <= 2'b00;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q <= byte_d;
      dib_q <= dib_d;
      crc_q <= crc_d;
      pl_q <= pl_d;
      txen_q <= txen_d;
      txd_q <= txd_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign txen = txen_q;
  assign txd = txd_q;
endmodule

// File: tb/tb_ether_frame_tx.sv
// tb_ether_frame_tx: scoreboard bench, stimulus queues expected dibit streams and monitors compare each transmitted frame
`timescale 1ns/1ps
module tb_ether_frame_tx;
  localparam logic [47:0] DST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC = 48'h000203040506;
  localparam logic [15:0] ET = 16'h1234;
`ifdef ETHER_TX_IFG_EN
  localparam int GAP = 49;
`else
  localparam int GAP = 1;
`endif
  logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0;
  logic [39:0] payload0 = '0;
  logic [479:0] payload1 = '0;
  logic busy0, txen0, busy1, txen1;
  logic [1:0] txd0, txd1;
  int tests = 0, fails = 0;
  logic [1:0] exp_d[2][$];
  int exp_n[2][$];
  int exp_gap[2][$];
  bit exp_res[2][$];
  logic [7:0] pb[$];

  always #10 clk = ~clk;

  ether_frame_tx #(.SRC_MAC(SRC), .DST_MAC(DST), .ETHERTYPE(ET), .PAYLOAD_LENGTH_BYTES(5)) dut0 (
    .clk(clk), .rst(rst), .payload(payload0), .start(start0), .busy(busy0), .txen(txen0), .txd(txd0));
  ether_frame_tx #(.SRC_MAC(SRC), .DST_MAC(DST), .ETHERTYPE(ET), .PAYLOAD_LENGTH_BYTES(60)) dut1 (
    .clk(clk), .rst(rst), .payload(payload1), .start(start1), .busy(busy1), .txen(txen1), .txd(txd1));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction

  // builds the reference frame from pb and queues its first n dibits (all if trunc is 0)
  task automatic push_frame(input int k, input int trunc, input int gap);
    logic [7:0] fb[$];
    logic [7:0] b;
    logic [31:0] c;
    logic [111:0] hdr;
    int n;
    hdr = {DST, SRC, ET};
    fb = {};
    for (int i = 0; i < 7; i++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    for (int i = 13; i >= 0; i--) fb.push_back(hdr[8*i +: 8]);
    foreach (pb[i]) fb.push_back(pb[i]);
    while (fb.size() < 68) fb.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < fb.size(); i++) c = crc_byte(c, fb[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
    n = trunc > 0 ? trunc : 4 * fb.size();
    for (int i = 0; i < n; i++) begin
      b = fb[i / 4];
      exp_d[k].push_back(b[2 * (i % 4) +: 2]);
    end
    exp_n[k].push_back(n);
    exp_res[k].push_back(trunc == 0);
    exp_gap[k].push_back(gap);
  endtask

  task automatic monitor(input int k);
    logic [1:0] got[$];
    logic [1:0] d, e;
    logic [31:0] c, rev;
    logic en, r;
    int low, gap, n, g, bad;
    low = -1;
    gap = -1;
    forever begin
      @(negedge clk);
      en = k == 0 ? txen0 : txen1;
      d = k == 0 ? txd0 : txd1;
      if (en) begin
        if (got.size() == 0) gap = low;
        got.push_back(d);
      end else begin
        check($sformatf("dut%0d idle txd", k), d, 0);
        if (got.size() > 0) begin
          check($sformatf("dut%0d frame expected", k), exp_n[k].size() > 0, 1);
          if (exp_n[k].size() > 0) begin
            n = exp_n[k].pop_front();
            r = exp_res[k].pop_front();
            g = exp_gap[k].pop_front();
            check($sformatf("dut%0d txen cycles", k), got.size(), n);
            bad = 0;
            for (int i = 0; i < n; i++) begin
              e = exp_d[k].pop_front();
              if (i >= got.size() || got[i] !== e) bad++;
            end
            check($sformatf("dut%0d wrong dibits", k), bad, 0);
            if (g >= 0) check($sformatf("dut%0d idle gap", k), gap, g);
            if (r) begin
              c = 32'hFFFFFFFF;
              for (int i = 8; i < got.size() / 4; i++)
                c = crc_byte(c, {got[4*i+3], got[4*i+2], got[4*i+1], got[4*i]});
              for (int i = 0; i < 32; i++) rev[i] = c[31-i];
              check($sformatf("dut%0d crc residue", k), rev, 32'hC704DD7B);
            end
          end
          got = {};
          low = 1;
        end else if (low >= 0) low++;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout, required finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    while ((k == 0 ? busy0 : busy1) && t < 2000) begin
      tick();
      t++;
    end
    check($sformatf("dut%0d idle within budget", k), t < 2000, 1);
  endtask

  initial begin
    tick(3);
    check("reset txen", txen0, 0);
    check("reset txd", txd0, 0);
    check("reset busy", busy0, 0);
    check("reset busy p60", busy1, 0);
    rst = 1'b0;
    tick();
    // frame 1: payload changes after accept, starts at N+10 and N+200 are dropped
    payload0 = 40'h0102030405;
    pb = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    push_frame(0, 0, -1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    payload0 = 40'hAABBCCDDEE;
    check("busy at N+1", busy0, 1);
    check("txen at N+1", txen0, 1);
    check("first txd", txd0, 2'b01);
    tick(9);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("busy after start N+10", busy0, 1);
    tick(21);
    check("sfd final dibit N+32", txd0, 2'b11);
    tick(168);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("busy after start N+200", busy0, 1);
    tick(87);
    check("txen at N+T", txen0, 1);
    tick();
    check("txen at N+T+1", txen0, 0);
    check("busy at N+T+1", busy0, GAP > 1);
    wait_idle(0);
    // start coincident with reset is dropped
    rst = 1'b1;
    start0 = 1'b1;
    tick();
    rst = 1'b0;
    start0 = 1'b0;
    check("start under reset busy", busy0, 0);
    check("start under reset txen", txen0, 0);
    tick(3);
    // reset in byte 20 truncates after 81 dibits
    push_frame(0, 81, -1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick(80);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("txen after mid-frame reset", txen0, 0);
    check("busy after mid-frame reset", busy0, 0);
    tick(3);
    payload0 = 40'hA1B2C3D4E5;
    pb = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    push_frame(0, 0, -1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_idle(0);
    tick(3);
    // start held high: back-to-back frames
    push_frame(0, 0, -1);
    push_frame(0, 0, GAP);
    start0 = 1'b1;
    tick();
    wait_idle(0);
    tick();
    start0 = 1'b0;
    check("busy for second held frame", busy0, 1);
    wait_idle(0);
    // 60-byte payload: no padding
    pb = {};
    for (int i = 0; i < 60; i++) begin
      pb.push_back(8'(i + 1));
      payload1[8*(59-i) +: 8] = 8'(i + 1);
    end
    push_frame(1, 0, -1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("p60 busy at N+1", busy1, 1);
    tick(343);
    check("p60 txen at N+344", txen1, 1);
    tick();
    check("p60 txen at N+345", txen1, 0);
    wait_idle(1);
    tick(5);
    check("dut0 frames outstanding", exp_n[0].size(), 0);
    check("dut1 frames outstanding", exp_n[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
